// File: rtl/mmcm_drp_responder.sv
// mmcm_drp_responder: DRP target emulating the MMCME2_ADV DRP port, config memory and LOCKED behaviour
module mmcm_drp_responder #(
    parameter int pADDR_WIDTH  = 7,
    parameter int pDATA_WIDTH  = 16,
    parameter int pRD_LATENCY  = 4,
    parameter int pWR_LATENCY  = 4,
    parameter int pLOCK_CYCLES = 64
) (
    input  logic                   clk_usb,
    input  logic                   reset_n,
    input  logic [pADDR_WIDTH-1:0] drp_addr,
    input  logic                   drp_den,
    input  logic                   drp_dwe,
    input  logic [pDATA_WIDTH-1:0] drp_din,
    output logic [pDATA_WIDTH-1:0] drp_dout,
    output logic                   drp_drdy,
    input  logic                   mmcm_rst,
    input  logic                   pwrdwn,
    output logic                   locked,
    input  logic                   err_clr,
    output logic [1:0]             err_flags
);
    localparam int LW = $clog2(pLOCK_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                 state, state_nxt;
    logic [3:0]             lat_cnt, lat_nxt, first_lat;
    logic [pADDR_WIDTH-1:0] addr_q, rd_addr;
    logic [pDATA_WIDTH-1:0] din_q;
    logic                   dwe_q, accept, rd_load;
    logic [1:0]             err_set;
    logic [LW-1:0]          lock_cnt, lock_nxt;
    logic [pDATA_WIDTH-1:0] mem [2**pADDR_WIDTH];

    // Next state, latency countdown and event decode; DONE is entered on the edge the counter leaves 1
    always_comb begin
        state_nxt = state;
        lat_nxt   = lat_cnt;
        accept    = 1'b0;
        first_lat = drp_dwe ? 4'(pWR_LATENCY - 1) : 4'(pRD_LATENCY - 1);
        case (state)
            IDLE: begin
                if (drp_den) begin
                    accept    = 1'b1;
                    lat_nxt   = first_lat;
                    state_nxt = (first_lat == 4'd0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                lat_nxt   = lat_cnt - 4'd1;
                state_nxt = (lat_cnt == 4'd1) ? DONE : BUSY;
            end
            default: state_nxt = IDLE;
        endcase
        rd_addr  = (state == IDLE) ? drp_addr : addr_q;
        rd_load  = (state_nxt == DONE) && !((state == IDLE) ? drp_dwe : dwe_q);
        err_set  = {accept && drp_dwe && !mmcm_rst, drp_den && (state != IDLE)};
        lock_nxt = (mmcm_rst || pwrdwn) ? '0 :
                   (lock_cnt == LW'(pLOCK_CYCLES)) ? lock_cnt : lock_cnt + 1'b1;
    end

    assign drp_drdy = (state == DONE);

    // FSM state, request latch and read-data register loaded on entry to DONE
    always_ff @(posedge clk_usb) begin
        if (!reset_n) begin
            state    <= IDLE;
            lat_cnt  <= '0;
            addr_q   <= '0;
            din_q    <= '0;
            dwe_q    <= 1'b0;
            drp_dout <= '0;
        end else begin
            state   <= state_nxt;
            lat_cnt <= lat_nxt;
            if (accept) begin
                addr_q <= drp_addr;
                din_q  <= drp_din;
                dwe_q  <= drp_dwe;
            end
            if (rd_load)
                drp_dout <= mem[rd_addr];
        end
    end

    // Configuration memory: cleared by reset, written in the DRDY cycle of a write
    always_ff @(posedge clk_usb) begin
        if (!reset_n) begin
            for (int i = 0; i < 2**pADDR_WIDTH; i++)
                mem[i] <= '0;
        end else if (state == DONE && dwe_q) begin
            mem[addr_q] <= din_q;
        end
    end

    // Lock counter saturates at pLOCK_CYCLES; locked tracks the post-increment value
    always_ff @(posedge clk_usb) begin
        if (!reset_n) begin
            lock_cnt <= '0;
            locked   <= 1'b0;
        end else begin
            lock_cnt <= lock_nxt;
            locked   <= (lock_nxt == LW'(pLOCK_CYCLES));
        end
    end

    // Sticky error flags; a new error beats a coincident clear
    always_ff @(posedge clk_usb) begin
        if (!reset_n)
            err_flags <= '0;
        else
            err_flags <= (err_clr ? 2'b00 : err_flags) | err_set;
    end
endmodule

// File: tb/tb_mmcm_drp_responder.sv
// tb_mmcm_drp_responder: randomized and directed check of two responder builds against a transaction-level model
module tb_mmcm_drp_responder;
    localparam int P = 64;

    logic clk_usb = 1'b0;
    always #5 clk_usb = ~clk_usb;

    logic        reset_n, den, dwe, mrst, pwr, clr;
    logic [6:0]  addr;
    logic [15:0] din;
    logic [15:0] dout0, dout1;
    logic        drdy0, drdy1, lck0, lck1;
    logic [1:0]  err0, err1;

    mmcm_drp_responder u0 (
        .clk_usb(clk_usb), .reset_n(reset_n), .drp_addr(addr), .drp_den(den), .drp_dwe(dwe),
        .drp_din(din), .drp_dout(dout0), .drp_drdy(drdy0), .mmcm_rst(mrst), .pwrdwn(pwr),
        .locked(lck0), .err_clr(clr), .err_flags(err0)
    );

    mmcm_drp_responder #(.pRD_LATENCY(1), .pWR_LATENCY(1)) u1 (
        .clk_usb(clk_usb), .reset_n(reset_n), .drp_addr(addr), .drp_den(den), .drp_dwe(dwe),
        .drp_din(din), .drp_dout(dout1), .drp_drdy(drdy1), .mmcm_rst(mrst), .pwrdwn(pwr),
        .locked(lck1), .err_clr(clr), .err_flags(err1)
    );

    int nchk = 0;
    int nerr = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        nchk++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
        end
    endtask

    // Transaction-level model: each instance has a latency, a pending request and a memory image
    int          lat [2] = '{4, 1};
    logic [15:0] mmem [2][128];
    logic [15:0] md [2];
    logic [1:0]  me [2];
    bit          mp [2], mr [2], mw [2];
    int          ml [2];
    logic [6:0]  ma [2];
    logic [15:0] mdi [2];
    int          rel = 0;
    bit          mrej, mfin;
    logic [1:0]  mset;

    always @(posedge clk_usb) begin
        if (!reset_n) begin
            rel = 0;
            for (int i = 0; i < 2; i++) begin
                for (int j = 0; j < 128; j++) mmem[i][j] = 16'h0;
                md[i] = 16'h0; me[i] = 2'b00; mp[i] = 0; mr[i] = 0; ml[i] = 0;
            end
        end else begin
            rel = (mrst || pwr) ? 0 : (rel < P ? rel + 1 : rel);
            for (int i = 0; i < 2; i++) begin
                mrej = mp[i] || mr[i];
                mset = 2'b00;
                mr[i] = 0;
                mfin = 0;
                if (mp[i]) begin
                    ml[i]--;
                    mfin = (ml[i] == 0);
                end else if (den && !mrej) begin
                    ma[i] = addr; mdi[i] = din; mw[i] = dwe;
                    mset[1] = dwe && !mrst;
                    if (lat[i] == 1) mfin = 1;
                    else begin mp[i] = 1; ml[i] = lat[i] - 1; end
                end
                if (mfin) begin
                    mp[i] = 0; mr[i] = 1;
                    if (mw[i]) mmem[i][ma[i]] = mdi[i];
                    else md[i] = mmem[i][ma[i]];
                end
                if (den && mrej) mset[0] = 1;
                me[i] = (clr ? 2'b00 : me[i]) | mset;
            end
        end
    end

    always @(negedge clk_usb) begin
        if (chk_en) begin
            chk("drdy0", drdy0, mr[0]);
            chk("dout0", dout0, md[0]);
            chk("err0",  err0,  me[0]);
            chk("lock0", lck0,  rel == P);
            chk("drdy1", drdy1, mr[1]);
            chk("dout1", dout1, md[1]);
            chk("err1",  err1,  me[1]);
            chk("lock1", lck1,  rel == P);
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin @(posedge clk_usb); #1; end
    endtask

    int          n, ndr;
    logic [15:0] q;

    // One DEN to both builds; returns u0 latency and the data seen in u0's DRDY cycle
    task automatic txn(input bit we, input logic [6:0] a, input logic [15:0] d,
                       output int lt, output logic [15:0] rd);
        den = 1; dwe = we; addr = a; din = d;
        step();
        den = 0;
        lt = 1;
        while (!drdy0 && lt < 40) begin step(); lt++; end
        rd = dout0;
        step();
    endtask

    initial begin
        reset_n = 0; den = 0; dwe = 0; addr = '0; din = '0; mrst = 1; pwr = 0; clr = 0;
        step(3);
        chk_en = 1;
        chk("rst_dout", dout0, 0);
        chk("rst_drdy", drdy0, 0);
        chk("rst_lock", lck0, 0);
        chk("rst_err", err0, 0);
        reset_n = 1;
        step(2);

        txn(1, 7'h08, 16'h1041, n, q);
        chk("wr_lat", n, 4);
        txn(0, 7'h08, 16'h0, n, q);
        chk("rd_lat", n, 4);
        chk("rd_data", q, 16'h1041);
        chk("t1_err", err0, 0);

        den = 1; dwe = 0; addr = 7'h7F;
        step();
        den = 0;
        step();
        den = 1; addr = 7'h20;
        step();
        den = 0;
        ndr = 0;
        for (int k = 0; k < 10; k++) begin
            if (drdy0) begin ndr++; q = dout0; end
            step();
        end
        chk("busy_drdys", ndr, 1);
        chk("busy_data", q, 16'h0000);
        chk("busy_err", err0, 2'b01);
        clr = 1;
        step();
        clr = 0;
        chk("clr_err", err0, 2'b00);

        mrst = 0;
        txn(1, 7'h4E, 16'hBEEF, n, q);
        chk("wr_norst_err", err0, 2'b10);
        txn(0, 7'h4E, 16'h0, n, q);
        chk("wr_norst_data", q, 16'hBEEF);
        den = 1; dwe = 1; addr = 7'h4E; din = 16'h1234; clr = 1;
        step();
        den = 0; clr = 0;
        chk("set_wins", err0, 2'b10);
        step(5);
        clr = 1;
        step();
        clr = 0;

        mrst = 1;
        step(10);
        mrst = 0;
        n = 0;
        while (!lck0 && n < 200) begin step(); n++; end
        chk("lock_time", n, 64);
        pwr = 1;
        step();
        chk("pwr_drop", lck0, 0);
        pwr = 0;
        n = 0;
        while (!lck0 && n < 200) begin step(); n++; end
        chk("relock_time", n, 64);

        den = 1; dwe = 1; addr = 7'h10; din = 16'h5555;
        step();
        den = 0;
        reset_n = 0;
        step();
        reset_n = 1;
        chk("abort_lock", lck0, 0);
        n = 0; ndr = 0;
        while (!lck0 && n < 200) begin
            if (drdy0) ndr++;
            step(); n++;
        end
        chk("abort_drdys", ndr, 0);
        chk("abort_relock", n, 64);
        txn(0, 7'h10, 16'h0, n, q);
        chk("abort_data", q, 16'h0000);

        mrst = 1;
        clr = 1;
        step();
        clr = 0;
        for (int pass = 0; pass < 2; pass++) begin
            for (int a = 0; a < 128; a++) begin
                den = 1; dwe = (pass == 0); addr = 7'(a); din = 16'(a * 16'h0203 + 16'h1111);
                step();
                den = 0;
                chk("fast_drdy", drdy1, 1);
                if (pass == 1) chk("fast_data", dout1, 16'(a * 16'h0203 + 16'h1111));
                step();
            end
        end
        chk("fast_err", err1, 2'b00);
        step(6);

        for (int c = 0; c < 4000; c++) begin
            den     = ($urandom_range(0, 2) == 0);
            dwe     = 1'($urandom);
            addr    = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'($urandom_range(0, 7));
            din     = 16'($urandom);
            clr     = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 99) == 0) mrst = ~mrst;
            if ($urandom_range(0, 149) == 0) pwr = ~pwr;
            reset_n = ($urandom_range(0, 999) != 0);
            step();
        end
        reset_n = 1; den = 0; clr = 0;
        step(2);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
